a_pin_entry: RTL and testbench

Keypad-to-checker front end. Collects up to 4 BCD digit keystrokes into a 16-bit candidate PIN (pw_16bit) and raises enough when the entry is complete. Sits directly upstream of the password checker. It consumes the checker's gen_rst to clear itself after each check, and honours the lockout (disable_cnt) by ignoring keys.

---
 rtl/a_lock_pkg.sv | 16 +
 rtl/a_pin_entry_if.sv | 25 ++
 rtl/a_idle_timer.sv | 26 ++
 rtl/a_pin_entry.sv | 95 +++++++++
 tb/tb_a_pin_entry.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/a_lock_pkg.sv
// rtl/a_lock_pkg.sv - shared key codes, entry states and PIN sizing for the lock datapath
package a_lock_pkg;

  localparam int PIN_W      = 16;
  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] KEY_BACK = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/a_pin_entry_if.sv
// rtl/a_pin_entry_if.sv - keypad-side and checker-side signals of the PIN entry block
interface a_pin_entry_if;
  import a_lock_pkg::*;

  logic             key_valid;
  logic [3:0]       key_code;
  logic             clr_entry;
  logic             disable_cnt;
  logic [PIN_W-1:0] pw_16bit;
  logic             enough;
  logic [2:0]       digit_cnt;
  logic             key_ack;
  logic             timeout_pulse;

  modport master (
    output key_valid, key_code, clr_entry, disable_cnt,
    input  pw_16bit, enough, digit_cnt, key_ack, timeout_pulse
  );

  modport slave (
    input  key_valid, key_code, clr_entry, disable_cnt,
    output pw_16bit, enough, digit_cnt, key_ack, timeout_pulse
  );

endinterface

// File: rtl/a_idle_timer.sv
// rtl/a_idle_timer.sv - inactivity counter that pulses done after LIMIT enabled cycles
module a_idle_timer #(
  parameter int LIMIT = 500,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CNT_W-1:0] count;

  // done is combinational so the owner can act on the very edge the limit is hit
  assign done = enable && !clear && (count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= done ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/a_pin_entry.sv
// rtl/a_pin_entry.sv - collects BCD keystrokes into a PIN; ENTRY_TIMEOUT_EN adds the idle timeout
module a_pin_entry
  import a_lock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic          clk,
  input  logic          reset,
  a_pin_entry_if.slave  bus
);

  state_e           state_q, state_d;
  logic [PIN_W-1:0] pw_q, pw_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             enough_q;
  logic             ack_q;
  logic             tmo_q, tmo_d;

  logic key_live, is_digit, is_back, is_clr, accept, expire;

  // A key only counts when neither the checker clear nor the lockout is pending
  assign key_live = bus.key_valid && !bus.clr_entry && !bus.disable_cnt;
  assign is_digit = (bus.key_code <= 4'd9);
  assign is_back  = (bus.key_code == KEY_BACK);
  assign is_clr   = (bus.key_code == KEY_CLR);
  assign accept   = key_live && ((is_digit && state_q != FULL) ||
                                 (is_back && state_q == ENTRY) || is_clr);

`ifdef ENTRY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic timer_clear;

  assign timer_clear = bus.clr_entry || bus.disable_cnt || accept || (state_q != ENTRY);

  a_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state_q == ENTRY),
    .done   (expire)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    if (bus.clr_entry || (accept && is_clr) || expire) begin
      state_d = IDLE;
      pw_d    = '0;
      cnt_d   = '0;
      tmo_d   = expire;
    end else if (accept && is_digit) begin
      pw_d    = {pw_q[PIN_W-5:0], bus.key_code};
      cnt_d   = cnt_q + 3'd1;
      state_d = (cnt_q == 3'(NUM_DIGITS - 1)) ? FULL : ENTRY;
    end else if (accept && is_back) begin
      pw_d    = {4'h0, pw_q[PIN_W-1:4]};
      cnt_d   = cnt_q - 3'd1;
      state_d = (cnt_q == 3'd1) ? IDLE : ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pw_q     <= '0;
      cnt_q    <= '0;
      enough_q <= 1'b0;
      ack_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      cnt_q    <= cnt_d;
      enough_q <= (cnt_d == 3'(NUM_DIGITS));
      ack_q    <= accept;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.pw_16bit      = pw_q;
  assign bus.enough        = enough_q;
  assign bus.digit_cnt     = cnt_q;
  assign bus.key_ack       = ack_q;
  assign bus.timeout_pulse = tmo_q;

endmodule

// File: tb/tb_a_pin_entry.sv
// tb/tb_a_pin_entry.sv - directed self-checking bench for a_pin_entry (with or without ENTRY_TIMEOUT_EN)
module tb_a_pin_entry;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int ack_total = 0;
  int tmo_total = 0;

  a_pin_entry_if bus();

`ifdef ENTRY_TIMEOUT_EN
  a_pin_entry #(.TIMEOUT_CYCLES(20)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  a_pin_entry dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.key_ack) ack_total++;
    if (bus.timeout_pulse) tmo_total++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.key_valid = 0; bus.key_code = 0; bus.clr_entry = 0; bus.disable_cnt = 0;
    reset = 1'b1;
    idle(3);
    checks++; if (bus.pw_16bit !== 16'h0000) begin errors++; $display("FAIL reset_pw: got %h expected 0000", bus.pw_16bit); end
    checks++; if (bus.digit_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.digit_cnt); end
    checks++; if (bus.enough !== 1'b0) begin errors++; $display("FAIL reset_enough: got %b expected 0", bus.enough); end
    checks++; if (bus.key_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.key_ack); end
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b expected 0", bus.timeout_pulse); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_fill;
    int a0;
    a0 = ack_total;
    press(4'h1); idle(1);
    press(4'h2); idle(1);
    press(4'h3);
    checks++; if (bus.enough !== 1'b0 || bus.digit_cnt !== 3'd3) begin errors++; $display("FAIL fill_three: got enough=%b cnt=%0d expected enough=0 cnt=3", bus.enough, bus.digit_cnt); end
    idle(1);
    press(4'h4);
    checks++; if (bus.pw_16bit !== 16'h1234) begin errors++; $display("FAIL fill_pw: got %h expected 1234", bus.pw_16bit); end
    checks++; if (bus.digit_cnt !== 3'd4) begin errors++; $display("FAIL fill_cnt: got %0d expected 4", bus.digit_cnt); end
    checks++; if (bus.enough !== 1'b1) begin errors++; $display("FAIL fill_enough: got %b expected 1", bus.enough); end
    idle(1);
    checks++; if (ack_total - a0 !== 4) begin errors++; $display("FAIL fill_acks: got %0d expected 4", ack_total - a0); end
    press(4'h5);
    checks++; if (bus.key_ack !== 1'b0) begin errors++; $display("FAIL full_digit_ack: got %b expected 0", bus.key_ack); end
    press(4'hA);
    checks++; if (bus.pw_16bit !== 16'h1234 || bus.key_ack !== 1'b0) begin errors++; $display("FAIL full_back: got pw=%h ack=%b expected pw=1234 ack=0", bus.pw_16bit, bus.key_ack); end
    press(4'hC);
    checks++; if (bus.pw_16bit !== 16'h0000 || bus.digit_cnt !== 3'd0 || bus.enough !== 1'b0 || bus.key_ack !== 1'b1) begin
      errors++; $display("FAIL clear_key: got pw=%h cnt=%0d enough=%b ack=%b expected 0000/0/0/1", bus.pw_16bit, bus.digit_cnt, bus.enough, bus.key_ack); end
    idle(1);
  endtask

  task automatic test_backspace;
    press(4'h7); press(4'h8); press(4'hA);
    checks++; if (bus.pw_16bit !== 16'h0007 || bus.key_ack !== 1'b1) begin errors++; $display("FAIL back_pw: got pw=%h ack=%b expected 0007/1", bus.pw_16bit, bus.key_ack); end
    press(4'h9);
    checks++; if (bus.pw_16bit !== 16'h0079 || bus.digit_cnt !== 3'd2) begin errors++; $display("FAIL back_digit: got pw=%h cnt=%0d expected 0079/2", bus.pw_16bit, bus.digit_cnt); end
    press(4'hA); press(4'hA);
    checks++; if (bus.pw_16bit !== 16'h0000 || bus.digit_cnt !== 3'd0 || bus.key_ack !== 1'b1) begin errors++; $display("FAIL back_to_idle: got pw=%h cnt=%0d ack=%b expected 0000/0/1", bus.pw_16bit, bus.digit_cnt, bus.key_ack); end
    press(4'hA);
    checks++; if (bus.key_ack !== 1'b0 || bus.digit_cnt !== 3'd0) begin errors++; $display("FAIL back_idle_noack: got ack=%b cnt=%0d expected 0/0", bus.key_ack, bus.digit_cnt); end
  endtask

  task automatic test_clr_entry;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    @(posedge clk); #1;
    bus.clr_entry = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'h6;
    @(posedge clk); #1;
    bus.clr_entry = 1'b0; bus.key_valid = 1'b0;
    checks++; if (bus.pw_16bit !== 16'h0000 || bus.digit_cnt !== 3'd0 || bus.enough !== 1'b0) begin
      errors++; $display("FAIL clr_entry: got pw=%h cnt=%0d enough=%b expected 0000/0/0", bus.pw_16bit, bus.digit_cnt, bus.enough); end
    checks++; if (bus.key_ack !== 1'b0) begin errors++; $display("FAIL clr_entry_ack: got %b expected 0", bus.key_ack); end
  endtask

  task automatic test_disable;
    int t0;
    bus.disable_cnt = 1'b1;
    press(4'h5);
    checks++; if (bus.pw_16bit !== 16'h0000 || bus.key_ack !== 1'b0) begin errors++; $display("FAIL disable_drop: got pw=%h ack=%b expected 0000/0", bus.pw_16bit, bus.key_ack); end
    bus.disable_cnt = 1'b0;
    press(4'h5);
    checks++; if (bus.pw_16bit !== 16'h0005 || bus.key_ack !== 1'b1) begin errors++; $display("FAIL disable_release: got pw=%h ack=%b expected 0005/1", bus.pw_16bit, bus.key_ack); end
    t0 = tmo_total;
    bus.disable_cnt = 1'b1;
    idle(30);
    checks++; if (bus.pw_16bit !== 16'h0005 || tmo_total !== t0) begin errors++; $display("FAIL disable_hold: got pw=%h pulses=%0d expected 0005/%0d", bus.pw_16bit, tmo_total, t0); end
    bus.disable_cnt = 1'b0;
    press(4'hC);
  endtask

  task automatic test_ignored;
    logic [3:0] codes [4];
    codes[0] = 4'hB; codes[1] = 4'hD; codes[2] = 4'hE; codes[3] = 4'hF;
    press(4'hF);
    checks++; if (bus.key_ack !== 1'b0 || bus.digit_cnt !== 3'd0) begin errors++; $display("FAIL ignore_idle: got ack=%b cnt=%0d expected 0/0", bus.key_ack, bus.digit_cnt); end
    press(4'h4);
    for (int i = 0; i < 4; i++) begin
      press(codes[i]);
      checks++; if (bus.key_ack !== 1'b0 || bus.pw_16bit !== 16'h0004 || bus.digit_cnt !== 3'd1) begin
        errors++; $display("FAIL ignore_%h: got ack=%b pw=%h cnt=%0d expected 0/0004/1", codes[i], bus.key_ack, bus.pw_16bit, bus.digit_cnt); end
    end
    press(4'hC);
  endtask

  task automatic test_reset_mid;
    press(4'h1); press(4'h2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.pw_16bit !== 16'h0000 || bus.digit_cnt !== 3'd0 || bus.enough !== 1'b0 || bus.key_ack !== 1'b0 || bus.timeout_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got pw=%h cnt=%0d enough=%b ack=%b tmo=%b expected all 0", bus.pw_16bit, bus.digit_cnt, bus.enough, bus.key_ack, bus.timeout_pulse); end
  endtask

  task automatic test_timeout;
    int t0;
    t0 = tmo_total;
`ifdef ENTRY_TIMEOUT_EN
    press(4'h3);
    idle(19);
    checks++; if (bus.timeout_pulse !== 1'b0 || bus.pw_16bit !== 16'h0003) begin errors++; $display("FAIL tmo_early: got tmo=%b pw=%h expected 0/0003", bus.timeout_pulse, bus.pw_16bit); end
    idle(1);
    checks++; if (bus.timeout_pulse !== 1'b1 || bus.pw_16bit !== 16'h0000 || bus.digit_cnt !== 3'd0) begin
      errors++; $display("FAIL tmo_fire: got tmo=%b pw=%h cnt=%0d expected 1/0000/0", bus.timeout_pulse, bus.pw_16bit, bus.digit_cnt); end
    idle(1);
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b expected 0", bus.timeout_pulse); end
    t0 = tmo_total;
    press(4'h1); idle(14);
    press(4'h2); idle(14);
    press(4'h3); idle(14);
    checks++; if (tmo_total !== t0 || bus.pw_16bit !== 16'h0123) begin errors++; $display("FAIL tmo_keepalive: got pulses=%0d pw=%h expected %0d/0123", tmo_total, bus.pw_16bit, t0); end
    press(4'hC);
`else
    press(4'h3);
    idle(40);
    checks++; if (tmo_total !== t0 || bus.pw_16bit !== 16'h0003 || bus.digit_cnt !== 3'd1) begin
      errors++; $display("FAIL no_timeout: got pulses=%0d pw=%h cnt=%0d expected %0d/0003/1", tmo_total, bus.pw_16bit, bus.digit_cnt, t0); end
    press(4'hC);
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backspace();
    test_clr_entry();
    test_disable();
    test_ignored();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
